// File: rtl/mips_cpu_harvard_pc.sv
// Fetch stage of the single-cycle Harvard MIPS CPU. Holds the PC and applies
// branch/jump redirects after one delay-slot instruction. Halts on HALT_ADDRESS or on a misaligned target.
module mips_cpu_harvard_pc #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] instr_readdata,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] rs_data,
    output logic [31:0] instr_address,
    output logic [5:0]  opcode,
    output logic [31:0] pc_plus8,
    output logic        active,
    output logic        addr_fault
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DELAY  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_r, state_next_s;
    logic [31:0] pc_r, pc_next_s;
    logic [31:0] target_r, target_next_s;
    logic        addr_fault_r, addr_fault_next_s;
    logic [31:0] pc_plus4_s;
    logic        redirect_s;
    logic [31:0] redirect_target_s;

    function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [15:0] imm);
        return pc4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    assign pc_plus4_s    = pc_r + 32'd4;
    assign instr_address = pc_r;
    assign pc_plus8      = pc_r + 32'd8;
    assign active        = (state_r != ST_HALTED);
    assign addr_fault    = addr_fault_r;
    assign opcode        = active ? instr_readdata[31:26] : 6'b000000;

    // Redirect target selection; jump_reg has priority over jump, which beats branch.
    always_comb begin
        redirect_s        = 1'b1;
        redirect_target_s = 32'd0;
        if (jump_reg) begin
            redirect_target_s = rs_data;
        end else if (jump) begin
            redirect_target_s = {pc_plus4_s[31:28], instr_readdata[25:0], 2'b00};
        end else if (branch_taken) begin
            redirect_target_s = branch_target(pc_plus4_s, instr_readdata[15:0]);
        end else begin
            redirect_s = 1'b0;
        end
    end

    // Next-state logic for PC, pending target, run state and fault flag.
    always_comb begin
        state_next_s      = state_r;
        pc_next_s         = pc_r;
        target_next_s     = target_r;
        addr_fault_next_s = addr_fault_r;
        if (clk_enable) begin
            case (state_r)
                ST_RUN: begin
                    pc_next_s = pc_plus4_s;
                    if (redirect_s) begin
                        state_next_s  = ST_DELAY;
                        target_next_s = redirect_target_s;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_DELAY: begin
                    // Redirects raised by the delay-slot instruction are ignored here.
                    pc_next_s = target_r;
                    if (target_r == HALT_ADDRESS) begin
                        state_next_s = ST_HALTED;
                    end else if (target_r[1:0] != 2'b00) begin
                        state_next_s      = ST_HALTED;
                        addr_fault_next_s = 1'b1;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_HALTED: begin
                    state_next_s = ST_HALTED;
                end
                default: begin
                    state_next_s = ST_HALTED;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State registers; reset wins over clk_enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r         <= RESET_VECTOR;
            target_r     <= 32'd0;
            state_r      <= ST_RUN;
            addr_fault_r <= 1'b0;
        end else begin
            pc_r         <= pc_next_s;
            target_r     <= target_next_s;
            state_r      <= state_next_s;
            addr_fault_r <= addr_fault_next_s;
        end
    end

endmodule

// File: tb/tb_mips_cpu_harvard_pc.sv
// Directed bench for the fetch stage: expected PC/active/fault values are queued
// before each clock edge and checked just after it.
module tb_mips_cpu_harvard_pc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic [31:0] instr_readdata = 32'h8C000000;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic        jump_reg = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] instr_address;
    logic [5:0]  opcode;
    logic [31:0] pc_plus8;
    logic        active;
    logic        addr_fault;

    typedef struct {
        logic [31:0] addr;
        logic        act;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    mips_cpu_harvard_pc dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .instr_readdata (instr_readdata),
        .branch_taken   (branch_taken),
        .jump           (jump),
        .jump_reg       (jump_reg),
        .rs_data        (rs_data),
        .instr_address  (instr_address),
        .opcode         (opcode),
        .pc_plus8       (pc_plus8),
        .active         (active),
        .addr_fault     (addr_fault)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [31:0] addr, input logic act, input logic fault);
        exp_t e;
        e.addr  = addr;
        e.act   = act;
        e.fault = fault;
        exp_q.push_back(e);
    endtask

    // Advance one clock and check the DUT against the oldest queued expectation.
    task automatic tick(input string tag);
        exp_t e;
        logic [5:0] exp_op;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            exp_op = e.act ? instr_readdata[31:26] : 6'b000000;
            cmp({tag, "_addr"},  instr_address, e.addr);
            cmp({tag, "_plus8"}, pc_plus8, e.addr + 32'd8);
            cmp({tag, "_active"}, {31'd0, active}, {31'd0, e.act});
            cmp({tag, "_fault"}, {31'd0, addr_fault}, {31'd0, e.fault});
            cmp({tag, "_opcode"}, {26'd0, opcode}, {26'd0, exp_op});
        end
    endtask

    initial begin
        // 1: reset and sequential fetch
        reset = 1'b1;
        push(32'hBFC00000, 1'b1, 1'b0); tick("reset");
        reset = 1'b0;
        push(32'hBFC00004, 1'b1, 1'b0); tick("seq1");
        push(32'hBFC00008, 1'b1, 1'b0); tick("seq2");
        push(32'hBFC0000C, 1'b1, 1'b0); tick("seq3");
        push(32'hBFC00010, 1'b1, 1'b0); tick("seq4");

        // 2: backward branch, imm = -4 words
        branch_taken = 1'b1; instr_readdata = 32'h1000FFFC;
        push(32'hBFC00014, 1'b1, 1'b0); tick("br_slot");
        branch_taken = 1'b0; instr_readdata = 32'h8C000000;
        push(32'hBFC00004, 1'b1, 1'b0); tick("br_tgt");
        for (int i = 0; i < 7; i++) begin
            push(32'hBFC00008 + 32'(i) * 32'd4, 1'b1, 1'b0); tick("walk");
        end

        // 3: jr to HALT_ADDRESS
        jump_reg = 1'b1; rs_data = 32'h00000000; instr_readdata = 32'h00000008;
        push(32'hBFC00024, 1'b1, 1'b0); tick("halt_slot");
        jump_reg = 1'b0; instr_readdata = 32'h8C000000;
        push(32'h00000000, 1'b0, 1'b0); tick("halt");
        branch_taken = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(32'h00000000, 1'b0, 1'b0); tick("halt_hold");
        end
        branch_taken = 1'b0;
        reset = 1'b1;
        push(32'hBFC00000, 1'b1, 1'b0); tick("halt_reset");
        reset = 1'b0;

        // 4: misaligned jr target
        jump_reg = 1'b1; rs_data = 32'h00001002;
        push(32'hBFC00004, 1'b1, 1'b0); tick("mis_slot");
        jump_reg = 1'b0;
        push(32'h00001002, 1'b0, 1'b1); tick("mis_halt");
        push(32'h00001002, 1'b0, 1'b1); tick("mis_hold");
        reset = 1'b1; clk_enable = 1'b0;
        push(32'hBFC00000, 1'b1, 1'b0); tick("mis_reset_stall");
        reset = 1'b0;

        // 5: branch held across a stall, then branch in delay slot ignored
        branch_taken = 1'b1; instr_readdata = 32'h10000004;
        for (int i = 0; i < 3; i++) begin
            push(32'hBFC00000, 1'b1, 1'b0); tick("stall");
        end
        clk_enable = 1'b1;
        push(32'hBFC00004, 1'b1, 1'b0); tick("stall_slot");
        instr_readdata = 32'h10000100;
        push(32'hBFC00014, 1'b1, 1'b0); tick("stall_tgt");
        branch_taken = 1'b0; instr_readdata = 32'h8C000000;
        push(32'hBFC00018, 1'b1, 1'b0); tick("stall_run");

        // 6: j keeps upper bits of pc+4; reset in delay slot drops the target
        jump_reg = 1'b1; rs_data = 32'h0FFFFFF8;
        push(32'hBFC0001C, 1'b1, 1'b0); tick("to_j_slot");
        jump_reg = 1'b0;
        push(32'h0FFFFFF8, 1'b1, 1'b0); tick("to_j");
        jump = 1'b1; instr_readdata = 32'h08000040;
        push(32'h0FFFFFFC, 1'b1, 1'b0); tick("j_slot");
        push(32'h00000100, 1'b1, 1'b0); tick("j_tgt");
        push(32'h00000104, 1'b1, 1'b0); tick("j2_slot");
        jump = 1'b0; reset = 1'b1;
        push(32'hBFC00000, 1'b1, 1'b0); tick("slot_reset");
        reset = 1'b0;
        push(32'hBFC00004, 1'b1, 1'b0); tick("slot_reset_run");

        // sequential wrap through zero is not a halt; jump_reg beats jump
        jump_reg = 1'b1; rs_data = 32'hFFFFFFF8;
        push(32'hBFC00008, 1'b1, 1'b0); tick("wrap_slot");
        jump_reg = 1'b0; instr_readdata = 32'h8C000000;
        push(32'hFFFFFFF8, 1'b1, 1'b0); tick("wrap_tgt");
        push(32'hFFFFFFFC, 1'b1, 1'b0); tick("wrap_top");
        push(32'h00000000, 1'b1, 1'b0); tick("wrap_zero");
        jump_reg = 1'b1; jump = 1'b1; rs_data = 32'h00000200; instr_readdata = 32'h08000040;
        push(32'h00000004, 1'b1, 1'b0); tick("prio_slot");
        jump_reg = 1'b0; jump = 1'b0; instr_readdata = 32'h8C000000;
        push(32'h00000200, 1'b1, 1'b0); tick("prio_tgt");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
